// File: rtl/intr_ctrl.sv
// Device-side interrupt controller: synchronises N request lines, latches edge or level
// requests, priority-resolves masked pending sources and runs the intr/inta/EOI handshake.
module intr_ctrl #(
    parameter int N    = 8,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] irq,
    output logic         intr,
    input  logic         inta,
    input  logic         sel,
    input  logic         we,
    input  logic [2:0]   addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] A_MASK = 3'd0;
    localparam logic [2:0] A_EDGE = 3'd1;
    localparam logic [2:0] A_PEND = 3'd2;
    localparam logic [2:0] A_VEC  = 3'd3;
    localparam logic [2:0] A_EOI  = 3'd4;

    state_t                 state, state_n;
    logic                   intr_n;
    logic [SYNC-1:0][N-1:0] sync_q;
    logic [N-1:0]           s, d;
    logic [N-1:0]           mask, edge_mode, pend, pend_n;
    logic [N-1:0]           active, win_oh, ack_clr, w1c;
    logic [4:0]             win_id, cur_id;
    logic                   cur_valid, spur, req;
    logic                   wr_en, rd_en, eoi, ack, spur_ack;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    assign wr_en    = sel & we;
    assign rd_en    = sel & ~we;
    assign eoi      = wr_en && (addr == A_EOI);
    assign w1c      = (wr_en && (addr == A_PEND)) ? wdata[N-1:0] : '0;
    assign ack      = (state == REQ) && inta && req;
    assign spur_ack = (state == REQ) && inta && !req;
    assign unused_wdata = ^wdata;

    // Last synchroniser stage is s; d is s one cycle later for rising-edge detection.
    assign s = sync_q[SYNC-1];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            d      <= '0;
        end else begin
            // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
            sync_q <= {sync_q[SYNC-2:0], irq};
            d      <= s;
        end
    end

    // Iterating from the top down leaves the lowest active index as the winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        active = pend & mask;
        win_oh = '0;
        win_id = '0;
        req    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = 5'(i);
                req       = 1'b1;
            end
        end
    end

    // Edge bits: a new edge wins over a W1C or acknowledge clear. Level bits follow s.
    always_comb begin
        ack_clr = ack ? win_oh : '0;
        pend_n  = (edge_mode & ((s & ~d) | (pend & ~(w1c | ack_clr)))) | (~edge_mode & s);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            intr  <= 1'b0;
        end else begin
            state <= state_n;
            intr  <= intr_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (intr && req) state_n = REQ;
            REQ:     if (inta)        state_n = req ? SERVICE : IDLE;
                     else if (!req)   state_n = IDLE;
            SERVICE: if (eoi)         state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    always_comb begin
        intr_n = 1'b0;
        case (state)
            IDLE:    intr_n = req;
            REQ:     intr_n = req && !inta;
            default: intr_n = 1'b0;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_MASK:  rd_mux = 32'(mask);
            A_EDGE:  rd_mux = 32'(edge_mode);
            A_PEND:  rd_mux = 32'(pend);
            A_VEC:   rd_mux = {cur_valid, 25'b0, spur, cur_id};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mask      <= '0;
            edge_mode <= '0;
            pend      <= '0;
            cur_id    <= '0;
            cur_valid <= 1'b0;
            spur      <= 1'b0;
            rdata     <= '0;
        end else begin
            pend <= pend_n;
            if (wr_en && (addr == A_MASK)) mask      <= wdata[N-1:0];
            if (wr_en && (addr == A_EDGE)) edge_mode <= wdata[N-1:0];
            if (rd_en)                     rdata     <= rd_mux;
            if (ack) begin
                cur_id    <= win_id;
                cur_valid <= 1'b1;
                spur      <= 1'b0;
            end else if (spur_ack) begin
                cur_id    <= '0;
                cur_valid <= 1'b0;
                spur      <= 1'b1;
            end else if (eoi && (state == SERVICE)) begin
                cur_valid <= 1'b0;
            end
        end
    end

endmodule
